// File: rtl/mire_pkg.sv
// Shared types and constants for the mire (grid test pattern) framebuffer writer.
package mire_pkg;

  typedef enum logic [1:0] {
    WRITE_INIT = 2'd0,
    WRITE      = 2'd1,
    PAUSE      = 2'd2
  } state_t;

  localparam logic [31:0] WHITE = 32'h00FF_FFFF;
  localparam logic [31:0] BLACK = 32'h0000_0000;

  localparam logic [3:0] SEL_ALL     = 4'b1111;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Counter width that stays legal (>=1) for degenerate parameter values.
  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mire_if.sv
// Wishbone classic bus bundle between the mire writer (master) and the intercon (slave).
interface mire_if;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    output adr, dat_ms, we, sel, stb, cyc, cti, bte,
    input  dat_sm, ack
  );

  modport slave (
    input  adr, dat_ms, we, sel, stb, cyc, cti, bte,
    output dat_sm, ack
  );
endinterface

// File: rtl/mire_pattern.sv
// Combinational grid colour: white on grid lines (shifted by offset) and on the right/bottom border.
module mire_pattern
  import mire_pkg::*;
#(
  parameter  int HDISP = 800,
  parameter  int VDISP = 480,
  parameter  int GRID  = 16,
  localparam int XW    = cnt_width(HDISP),
  localparam int YW    = cnt_width(VDISP),
  localparam int OW    = cnt_width(GRID)
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [OW-1:0] offset,
  output logic [31:0]   pixel
);

  localparam logic [XW-1:0] XMASK = XW'(GRID - 1);
  localparam logic [YW-1:0] YMASK = YW'(GRID - 1);

  logic [XW-1:0] xs;
  logic [YW-1:0] ys;
  logic          on_grid;
  logic          on_border;

  // GRID is a power of two, so the modulo reduces to a mask.
  assign xs        = x + XW'(offset);
  assign ys        = y + YW'(offset);
  assign on_grid   = ((xs & XMASK) == '0) || ((ys & YMASK) == '0);
  assign on_border = (x == XW'(HDISP - 1)) || (y == YW'(VDISP - 1));
  assign pixel     = (on_grid || on_border) ? WHITE : BLACK;

endmodule

// File: rtl/mire_writer.sv
// Wishbone master that continuously fills the framebuffer with a grid test pattern.
// Optional MIRE_SCROLL_EN: grid offset advances by one pixel per frame (diagonal scroll).
//
// state      | meaning
// WRITE_INIT | one idle cycle (cyc=0) after reset release
// WRITE      | cyc=stb=1, one word per ack, up to BURST_LEN acks
// PAUSE      | cyc=0 for PAUSE_LEN cycles so the VGA reader can be granted
module mire_writer
  import mire_pkg::*;
#(
  parameter int HDISP     = 800,
  parameter int VDISP     = 480,
  parameter int BURST_LEN = 64,
  parameter int PAUSE_LEN = 1,
  parameter int GRID      = 16
) (
  input  logic     clk,
  input  logic     rst,
  mire_if.master   bus,
  output logic     frame_done
);

  localparam int XW = cnt_width(HDISP);
  localparam int YW = cnt_width(VDISP);
  localparam int BW = cnt_width(BURST_LEN);
  localparam int PW = cnt_width(PAUSE_LEN);
  localparam int OW = cnt_width(GRID);

  state_t        state;
  state_t        state_nxt;
  logic [XW-1:0] x;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y;
  logic [YW-1:0] y_nxt;
  logic [BW-1:0] burst_cnt;
  logic [PW-1:0] pause_cnt;
  logic [OW-1:0] offset_nxt;
  logic          acc;
  logic          line_end;
  logic          frame_end;
  logic          burst_end;
  logic [31:0]   adr_nxt;
  logic [31:0]   pixel_nxt;
  logic          unused_dat_sm;

  assign unused_dat_sm = ^bus.dat_sm;

  assign bus.we  = 1'b1;
  assign bus.sel = SEL_ALL;
  assign bus.cti = CTI_CLASSIC;
  assign bus.bte = BTE_LINEAR;

  // stb is only high in WRITE, so an ack outside WRITE is ignored here.
  assign acc       = (state == WRITE) && bus.ack;
  assign line_end  = (x == XW'(HDISP - 1));
  assign frame_end = line_end && (y == YW'(VDISP - 1));
  assign burst_end = (burst_cnt == BW'(BURST_LEN - 1));

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (acc) begin
      if (line_end) begin
        x_nxt = '0;
        y_nxt = frame_end ? '0 : y + 1'b1;
      end else begin
        x_nxt = x + 1'b1;
      end
    end
  end

`ifdef MIRE_SCROLL_EN
  logic [OW-1:0] offset;

  assign offset_nxt = (acc && frame_end) ? offset + 1'b1 : offset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) offset <= '0;
    else     offset <= offset_nxt;
  end
`else
  assign offset_nxt = '0;
`endif

  // Address and data are registered from the post-ack coordinates.
  assign adr_nxt = (32'(x_nxt) + 32'(y_nxt) * 32'(HDISP)) << 2;

  mire_pattern #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .GRID  (GRID)
  ) u_pattern (
    .x      (x_nxt),
    .y      (y_nxt),
    .offset (offset_nxt),
    .pixel  (pixel_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      burst_cnt  <= '0;
      pause_cnt  <= '0;
      bus.adr    <= '0;
      bus.dat_ms <= WHITE;
      frame_done <= 1'b0;
    end else begin
      x          <= x_nxt;
      y          <= y_nxt;
      bus.adr    <= adr_nxt;
      bus.dat_ms <= pixel_nxt;
      frame_done <= acc && frame_end;
      if (acc) begin
        burst_cnt <= burst_end ? '0 : burst_cnt + 1'b1;
      end
      if (acc && burst_end) begin
        pause_cnt <= PW'(PAUSE_LEN - 1);
      end else if ((state == PAUSE) && (pause_cnt != '0)) begin
        pause_cnt <= pause_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WRITE_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WRITE_INIT: state_nxt = WRITE;
      WRITE:      if (acc && burst_end) state_nxt = PAUSE;
      PAUSE:      if (pause_cnt == '0) state_nxt = WRITE;
      default:    state_nxt = WRITE_INIT;
    endcase
  end

  // Decoded from the state register, so an async reset drops cyc/stb at once.
  always_comb begin
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    if (state == WRITE) begin
      bus.cyc = 1'b1;
      bus.stb = 1'b1;
    end
  end

endmodule
